// File: rtl/ras_spec_ctrl.sv
// ras_spec_ctrl: speculation controller for the fetch-stage return address stack.
// Turns call/return decodes into RAS push/pop strobes, supplies the predicted
// return target, keeps a {depth, top} checkpoint per branch tag and, on a
// mispredict, walks the RAS back to the checkpointed depth one op per cycle
// before applying the resolving instruction's own push/pop.
module ras_spec_ctrl #(
  parameter int DEPTH    = 8,
  parameter int NUM_CKPT = 16,
  parameter int TAG_W    = $clog2(NUM_CKPT)
) (
  input  logic                     clock,
  input  logic                     reset,
  // fetch-stage decode
  input  logic                     f_valid,
  input  logic                     f_is_call,
  input  logic                     f_is_ret,
  input  logic [31:0]              f_pc,
  output logic                     f_ready,
  // checkpoint allocation
  input  logic                     br_alloc,
  input  logic [TAG_W-1:0]         br_tag,
  // return prediction
  output logic                     pred_valid,
  output logic [31:0]              pred_target,
  // mispredict recovery
  input  logic                     rec_valid,
  input  logic [TAG_W-1:0]         rec_tag,
  input  logic [1:0]               rec_op,
  input  logic [31:0]              rec_push_addr,
  // attached RAS
  output logic                     ras_w_en,
  output logic                     ras_r_en,
  output logic [31:0]              ras_waddr,
  input  logic [31:0]              ras_raddr,
  // status
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     busy
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] ONE       = DW'(1);
  localparam logic [DW-1:0] ZERO      = '0;

  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPAIR = 2'd1,
    FIXUP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [DW-1:0]   tgt_depth_q, tgt_depth_d;
  logic [31:0]     tgt_top_q, tgt_top_d;
  logic [1:0]      fix_op_q, fix_op_d;
  logic [31:0]     fix_addr_q, fix_addr_d;

  // Checkpoint storage, one {depth, top} pair per branch tag. Not reset:
  // a slot is always written by br_alloc before a recovery may name it.
  logic [DW-1:0]   ckpt_depth_mem [NUM_CKPT];
  logic [31:0]     ckpt_top_mem   [NUM_CKPT];
  logic            ckpt_we;
  logic [DW-1:0]   ckpt_depth_rd;
  logic [31:0]     ckpt_top_rd;

  logic            fetch_acc;
  logic [DW-1:0]   depth_inc_sat;
  logic [DW-1:0]   depth_dec;
  logic [DW-1:0]   depth_inc;

  // The checkpoint is read in the rec_valid cycle itself so the FSM can skip
  // REPAIR entirely when the stack is already at the checkpointed depth.
  assign ckpt_depth_rd = ckpt_depth_mem[rec_tag];
  assign ckpt_top_rd   = ckpt_top_mem[rec_tag];

  // A push at full depth overwrites the oldest RAS entry, so depth saturates.
  assign depth_inc     = depth_q + ONE;
  assign depth_inc_sat = (depth_q == DEPTH_MAX) ? DEPTH_MAX : depth_inc;
  assign depth_dec     = depth_q - ONE;

  assign fetch_acc = f_valid && f_ready;
  assign depth     = depth_q;
  assign busy      = (state_q != IDLE);

  // Checkpoint write: capture depth and top as they stood before this cycle's op.
  always_ff @(posedge clock) begin
    if (ckpt_we) begin
      ckpt_depth_mem[br_tag] <= depth_q;
      ckpt_top_mem[br_tag]   <= ras_raddr;
    end
  end

  // State, depth and latched recovery context registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      tgt_depth_q <= '0;
      tgt_top_q   <= '0;
      fix_op_q    <= '0;
      fix_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      tgt_depth_q <= tgt_depth_d;
      tgt_top_q   <= tgt_top_d;
      fix_op_q    <= fix_op_d;
      fix_addr_q  <= fix_addr_d;
    end
  end

  // Next-state logic and combinational RAS strobes; recovery overrides everything.
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    tgt_depth_d = tgt_depth_q;
    tgt_top_d   = tgt_top_q;
    fix_op_d    = fix_op_q;
    fix_addr_d  = fix_addr_q;
    f_ready     = (state_q == IDLE) && !rec_valid;
    ras_w_en    = 1'b0;
    ras_r_en    = 1'b0;
    ras_waddr   = '0;
    pred_valid  = 1'b0;
    pred_target = '0;
    ckpt_we     = 1'b0;

    if (rec_valid) begin
      // Latch the target and the resolving op; no RAS traffic this cycle.
      tgt_depth_d = ckpt_depth_rd;
      tgt_top_d   = ckpt_top_rd;
      fix_op_d    = rec_op;
      fix_addr_d  = rec_push_addr;
      state_d     = (depth_q == ckpt_depth_rd) ? FIXUP : REPAIR;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_acc) begin
            ckpt_we = br_alloc;
            if (f_is_call) begin
              // A call wins when both decode bits are set.
              ras_w_en  = 1'b1;
              ras_waddr = f_pc + 32'd4;
              depth_d   = depth_inc_sat;
            end else if (f_is_ret && (depth_q != ZERO)) begin
              pred_valid  = 1'b1;
              pred_target = ras_raddr;
              ras_r_en    = 1'b1;
              depth_d     = depth_dec;
            end
          end
        end

        REPAIR: begin
          // Move one entry toward the target; leave for FIXUP on the op that
          // lands on it so the walk costs exactly one cycle per entry.
          if (depth_q > tgt_depth_q) begin
            ras_r_en = 1'b1;
            depth_d  = depth_dec;
            if (depth_dec == tgt_depth_q) begin
              state_d = FIXUP;
            end
          end else if (depth_q < tgt_depth_q) begin
            // Entries lost since the checkpoint are refilled with its top.
            ras_w_en  = 1'b1;
            ras_waddr = tgt_top_q;
            depth_d   = depth_inc;
            if (depth_inc == tgt_depth_q) begin
              state_d = FIXUP;
            end
          end else begin
            state_d = FIXUP;
          end
        end

        FIXUP: begin
          // Replay the resolving instruction's own op; reserved code is a no-op.
          if (fix_op_q == OP_PUSH) begin
            ras_w_en  = 1'b1;
            ras_waddr = fix_addr_q;
            depth_d   = depth_inc_sat;
          end else if ((fix_op_q == OP_POP) && (depth_q != ZERO)) begin
            ras_r_en = 1'b1;
            depth_d  = depth_dec;
          end
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Keep the RAS and checkpoints quiet while reset is held.
    if (reset) begin
      ras_w_en    = 1'b0;
      ras_r_en    = 1'b0;
      ras_waddr   = '0;
      pred_valid  = 1'b0;
      pred_target = '0;
      ckpt_we     = 1'b0;
    end
  end

endmodule
